// File: rtl/lvds_map_pkg.sv
// LVDS lane bit placement shared by the transmit and receive mappers.
// Pixel bundle type used by the group buffer.
package lvds_map_pkg;

  localparam int LVDS_WORD_W = 28;
  localparam int HS_POS      = 10;
  localparam int VS_POS      = 6;
  localparam int DE_POS      = 2;
  localparam int RSV_POS     = 3;

  // Element [i] is the lane bit carrying colour bit i.
  localparam logic [7:0][4:0] R_POS = {
    5'd23, 5'd27, 5'd4, 5'd8,
    5'd12, 5'd16, 5'd20, 5'd24
  };
  localparam logic [7:0][4:0] G_POS = {
    5'd15, 5'd19, 5'd9, 5'd13,
    5'd17, 5'd21, 5'd25, 5'd0
  };
  localparam logic [7:0][4:0] B_POS = {
    5'd7, 5'd11, 5'd14, 5'd18,
    5'd22, 5'd26, 5'd1, 5'd5
  };

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       hs;
    logic       vs;
    logic       de;
  } pix_t;

endpackage

// File: rtl/lvds_lane_pack.sv
// Combinational mapping of one pixel onto a 28-bit LVDS lane word.
// Reserved bit stays 0.
module lvds_lane_pack
  import lvds_map_pkg::*;
(
  input  logic [7:0]             r,
  input  logic [7:0]             g,
  input  logic [7:0]             b,
  input  logic                   hs,
  input  logic                   vs,
  input  logic                   de,
  output logic [LVDS_WORD_W-1:0] word
);

  always_comb begin
    word = '0;
    for (int i = 0; i < 8; i++) begin
      word[R_POS[i]] = r[i];
      word[G_POS[i]] = g[i];
      word[B_POS[i]] = b[i];
    end
    word[HS_POS]  = hs;
    word[VS_POS]  = vs;
    word[DE_POS]  = de;
    word[RSV_POS] = 1'b0;
  end

endmodule

// File: rtl/native_to_lvdsdata.sv
// Gathers C_PORT_NUM pixels into one multi-lane LVDS word.
// DE changes mid-group flush the partial group to realign.
module native_to_lvdsdata
  import lvds_map_pkg::*;
#(
  parameter int C_PORT_NUM = 4
) (
  input  logic                            CLK_I,
  input  logic                            RSTN_I,
  input  logic [7:0]                      PIX_R_I,
  input  logic [7:0]                      PIX_G_I,
  input  logic [7:0]                      PIX_B_I,
  input  logic                            PIX_HS_I,
  input  logic                            PIX_VS_I,
  input  logic                            PIX_DE_I,
  input  logic                            PIX_VLD_I,
  input  logic                            ERR_CLR_I,
  output logic [LVDS_WORD_W*C_PORT_NUM-1:0] LVDS_DATA_O,
  output logic                            LVDS_VLD_O,
  output logic                            ALIGN_ERR_O
);

  localparam int CW =
    (C_PORT_NUM > 1) ? $clog2(C_PORT_NUM) : 1;
  localparam logic [CW-1:0] LAST = CW'(C_PORT_NUM - 1);

  pix_t            pix;
  pix_t            slots [C_PORT_NUM];
  pix_t            grp   [C_PORT_NUM];
  logic [CW-1:0]   cnt;
  logic            last_hs;
  logic            last_vs;
  logic            last_de;
  logic            flush;
  logic            full;
  logic            err_set;
  logic [LVDS_WORD_W*C_PORT_NUM-1:0] grp_word;

  assign pix = '{PIX_R_I, PIX_G_I, PIX_B_I,
                 PIX_HS_I, PIX_VS_I, PIX_DE_I};

  assign flush = PIX_VLD_I && (cnt != '0) &&
                 (PIX_DE_I != last_de);
  assign full  = PIX_VLD_I && !flush && (cnt == LAST);
  assign err_set = flush && last_de && !PIX_DE_I;

  // Flush pads unfilled lanes; a full group takes the live pixel last.
  always_comb begin
    for (int k = 0; k < C_PORT_NUM; k++) begin
      grp[k] = slots[k];
      if (flush && k >= int'(cnt))
        grp[k] = '{8'h0, 8'h0, 8'h0, last_hs, last_vs, 1'b0};
      else if (!flush && k == C_PORT_NUM - 1)
        grp[k] = pix;
    end
  end

  for (genvar k = 0; k < C_PORT_NUM; k++) begin : g_lane
    lvds_lane_pack u_lane (
      .r    (grp[k].r),
      .g    (grp[k].g),
      .b    (grp[k].b),
      .hs   (grp[k].hs),
      .vs   (grp[k].vs),
      .de   (grp[k].de),
      .word (grp_word[LVDS_WORD_W*k +: LVDS_WORD_W])
    );
  end

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      cnt         <= '0;
      last_hs     <= 1'b0;
      last_vs     <= 1'b0;
      last_de     <= 1'b0;
      LVDS_DATA_O <= '0;
      LVDS_VLD_O  <= 1'b0;
      for (int k = 0; k < C_PORT_NUM; k++)
        slots[k] <= '0;
    end else begin
      LVDS_VLD_O <= full || flush;
      if (full || flush)
        LVDS_DATA_O <= grp_word;
      if (PIX_VLD_I) begin
        last_hs <= PIX_HS_I;
        last_vs <= PIX_VS_I;
        last_de <= PIX_DE_I;
        for (int k = 0; k < C_PORT_NUM; k++)
          if (k == (flush ? 0 : int'(cnt)))
            slots[k] <= pix;
        if (flush)
          cnt <= CW'(1);
        else if (full)
          cnt <= '0;
        else
          cnt <= cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I)
      ALIGN_ERR_O <= 1'b0;
    else if (err_set)
      ALIGN_ERR_O <= 1'b1;
    else if (ERR_CLR_I)
      ALIGN_ERR_O <= 1'b0;
  end

endmodule

// File: tb/tb_native_to_lvdsdata.sv
// Directed bench: 4-port and 1-port instances share one pixel stream.
// Expected lane words are hand-computed from the bit placement table.
module tb_native_to_lvdsdata;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   r, g, b;
  logic         hs, vs, de, vld, clr;
  logic [111:0] d4;
  logic         v4, e4;
  logic [27:0]  d1;
  logic         v1, e1;
  int           vec_n = 0;
  int           bad_n = 0;

  always #5 clk = ~clk;

  native_to_lvdsdata #(.C_PORT_NUM(4)) u_dut4 (
    .CLK_I(clk), .RSTN_I(rst_n),
    .PIX_R_I(r), .PIX_G_I(g), .PIX_B_I(b),
    .PIX_HS_I(hs), .PIX_VS_I(vs), .PIX_DE_I(de),
    .PIX_VLD_I(vld), .ERR_CLR_I(clr),
    .LVDS_DATA_O(d4), .LVDS_VLD_O(v4), .ALIGN_ERR_O(e4)
  );

  native_to_lvdsdata #(.C_PORT_NUM(1)) u_dut1 (
    .CLK_I(clk), .RSTN_I(rst_n),
    .PIX_R_I(r), .PIX_G_I(g), .PIX_B_I(b),
    .PIX_HS_I(hs), .PIX_VS_I(vs), .PIX_DE_I(de),
    .PIX_VLD_I(vld), .ERR_CLR_I(clr),
    .LVDS_DATA_O(d1), .LVDS_VLD_O(v1), .ALIGN_ERR_O(e1)
  );

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    vec_n++;
    if (got !== exp) begin
      bad_n++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  task automatic px(input logic [7:0] rr, gg, bb,
                    input logic h, vv, dd, v);
    @(negedge clk);
    r = rr; g = gg; b = bb;
    hs = h; vs = vv; de = dd; vld = v;
  endtask

  task automatic idle();
    px(8'h0, 8'h0, 8'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0;
    r = '0; g = '0; b = '0;
    hs = 0; vs = 0; de = 0; vld = 0;
    repeat (2) @(negedge clk);
    chk("rst_d4", d4, 0);
    chk("rst_v4", v4, 0);
    chk("rst_e4", e4, 0);
    chk("rst_d1", d1, 0);
    chk("rst_v1", v1, 0);
    chk("rst_e1", e1, 0);
    rst_n = 1'b1;

    // four red pixels back to back
    repeat (3) px(8'hFF, 8'h0, 8'h0, 0, 0, 1, 1);
    px(8'hFF, 8'h0, 8'h0, 0, 0, 1, 1);
    chk("t1_early", v4, 0);
    idle();
    chk("t1_vld", v4, 1);
    chk("t1_data", d4, {4{28'h9911114}});
    idle();
    chk("t1_vld_drop", v4, 0);
    chk("t1_hold", d4, {4{28'h9911114}});

    // single-lane words, DE low
    px(8'h0, 8'hFF, 8'h0, 0, 0, 0, 1);
    px(8'h0, 8'h0, 8'h0, 1, 0, 0, 1);
    chk("t2_g_vld", v1, 1);
    chk("t2_g", d1, 28'h22AA201);
    px(8'h0, 8'h0, 8'h0, 0, 1, 0, 1);
    chk("t2_hs", d1, 28'h400);
    px(8'h0, 8'h0, 8'hFF, 0, 0, 0, 1);
    chk("t2_vs", d1, 28'h40);
    idle();
    chk("t2_b", d1, 28'h44448A2);
    chk("t2_rsv", d1[3], 0);
    chk("t2_g4_vld", v4, 1);
    chk("t2_g4", d4, {28'h44448A2, 28'h40,
                      28'h400, 28'h22AA201});
    chk("t2_err", e4, 0);
    idle();
    chk("t2_v1_drop", v1, 0);

    // gaps inside a group
    px(8'hFF, 8'h0, 8'h0, 0, 0, 1, 1);
    idle();
    px(8'h0, 8'hFF, 8'h0, 0, 0, 1, 1);
    idle();
    px(8'h0, 8'h0, 8'hFF, 0, 0, 1, 1);
    chk("t3_gap_a", v4, 0);
    idle();
    px(8'h0, 8'h0, 8'h0, 1, 0, 1, 1);
    chk("t3_gap_b", v4, 0);
    idle();
    chk("t3_vld", v4, 1);
    chk("t3_order", d4, {28'h404, 28'h44448A6,
                         28'h22AA205, 28'h9911114});
    idle();
    chk("t3_once", v4, 0);

    // six-pixel line, then DE falls mid-group
    repeat (4) px(8'hFF, 8'h0, 8'h0, 0, 0, 1, 1);
    px(8'h0, 8'hFF, 8'h0, 0, 0, 1, 1);
    chk("t4_grp_vld", v4, 1);
    chk("t4_grp", d4, {4{28'h9911114}});
    px(8'h0, 8'h0, 8'hFF, 1, 1, 1, 1);
    chk("t4_p6", v4, 0);
    px(8'h0, 8'h0, 8'h0, 0, 0, 0, 1);
    chk("t4_p7", v4, 0);
    idle();
    chk("t4_fl_vld", v4, 1);
    chk("t4_flush", d4, {28'h440, 28'h440,
                         28'h4444CE6, 28'h22AA205});
    chk("t4_err_set", e4, 1);
    idle();
    clr = 1'b1;
    chk("t4_err_sticky", e4, 1);
    chk("t4_fl_once", v4, 0);
    idle();
    clr = 1'b0;
    chk("t4_err_clr", e4, 0);

    // blanking of three, then DE rises
    px(8'h0, 8'h0, 8'h0, 1, 0, 0, 1);
    px(8'h0, 8'h0, 8'h0, 0, 1, 0, 1);
    px(8'hFF, 8'h0, 8'h0, 0, 0, 1, 1);
    px(8'h0, 8'hFF, 8'h0, 0, 0, 1, 1);
    chk("t5_fl_vld", v4, 1);
    chk("t5_flush", d4, {28'h40, 28'h40,
                         28'h400, 28'h0});
    chk("t5_no_err", e4, 0);
    px(8'h0, 8'hFF, 8'h0, 0, 0, 1, 1);
    chk("t5_mid", v4, 0);
    px(8'h0, 8'hFF, 8'h0, 0, 0, 1, 1);
    idle();
    chk("t5_vld", v4, 1);
    chk("t5_line", d4, {28'h22AA205, 28'h22AA205,
                        28'h22AA205, 28'h9911114});
    chk("t5_err", e4, 0);

    // reset in the middle of a group
    repeat (2) px(8'hFF, 8'h0, 8'h0, 0, 0, 1, 1);
    @(negedge clk);
    vld = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_d4", d4, 0);
    chk("t6_v4", v4, 0);
    chk("t6_d1", d1, 0);
    chk("t6_v1", v1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) px(8'h0, 8'h0, 8'hFF, 0, 0, 1, 1);
    chk("t6_stale_a", v4, 0);
    px(8'h0, 8'h0, 8'hFF, 0, 0, 1, 1);
    chk("t6_stale_b", v4, 0);
    idle();
    chk("t6_vld", v4, 1);
    chk("t6_data", d4, {4{28'h44448A6}});
    chk("t6_e1", e1, 0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==",
             vec_n, bad_n);
    $finish;
  end

endmodule

// File: doc/native_to_lvdsdata.md
Name: native_to_lvdsdata

Overview:
- Transmit-side counterpart of the LVDS receive mapper.
- Accepts a one-pixel-per-clock native video stream (R/G/B 8 bit each, HS, VS, DE) with a valid qualifier.
- Gathers C_PORT_NUM consecutive pixels into one group and maps each pixel onto a 28-bit LVDS lane word (VESA/JEIDA-style bit placement used by the receiver).
- Emits the concatenated C_PORT_NUM*28-bit word with a valid strobe for the downstream serializer.

Parameters:
C_PORT_NUM, 4, number of LVDS ports (pixels per output word), legal 1..8

Ports:
CLK_I  in  1  pixel/system clock
RSTN_I  in  1  asynchronous active-low reset
PIX_R_I  in  8  red
PIX_G_I  in  8  green
PIX_B_I  in  8  blue
PIX_HS_I  in  1  hsync
PIX_VS_I  in  1  vsync
PIX_DE_I  in  1  data enable
PIX_VLD_I  in  1  pixel qualifier; pixel accepted on any cycle it is high (no backpressure)
ERR_CLR_I  in  1  clears ALIGN_ERR_O
LVDS_DATA_O  out  28*C_PORT_NUM  port k at [28k+27:28k]; port 0 = first pixel of group, at LSBs
LVDS_VLD_O  out  1  one-cycle strobe, LVDS_DATA_O valid
ALIGN_ERR_O  out  1  sticky: active line ended on a partial group

Behaviour:
- Clock/reset: one clock CLK_I; reset RSTN_I is asynchronous, active-low.
- Reset values: LVDS_DATA_O=0, LVDS_VLD_O=0, ALIGN_ERR_O=0, slot counter=0, group buffer=0, last-pixel sync/DE regs=0.
- Per-lane mapping of a 28-bit word w:
  - w[10]=HS, w[6]=VS, w[2]=DE.
  - R[7:0] -> w[23,27,4,8,12,16,20,24].
  - G[7:0] -> w[15,19,9,13,17,21,25,0].
  - B[7:0] -> w[7,11,14,18,22,26,1,5].
  - w[3] reserved, always 0.
- Slot counter 0..C_PORT_NUM-1 advances on each accepted pixel; the pixel is stored in slot = counter.
- On acceptance into the last slot:
  - Next cycle LVDS_DATA_O = full group, LVDS_VLD_O=1.
  - Counter wraps to 0.
  - Latency: 1 cycle from the last pixel of a group.
- LVDS_DATA_O holds its value between strobes. LVDS_VLD_O=0 otherwise.
- Group phase realign: an accepted pixel whose DE differs from the previous accepted pixel's DE (either edge), while counter≠0, triggers a flush.
  - Next cycle, emit the partial group with LVDS_VLD_O=1.
  - Unfilled slots: R=G=B=0, DE=0, HS/VS copied from the previous accepted pixel.
  - The same-cycle pixel is stored in slot 0; counter becomes 1. If C_PORT_NUM=1, it is also emitted as a full group on that next cycle.
  - If C_PORT_NUM≥2 and the new pixel completes nothing, the flush word is the only output that cycle.
- ALIGN_ERR_O: set the cycle after a flush caused by DE falling (1->0). A DE-rising flush (odd blanking length) is not an error.
- ERR_CLR_I: clears ALIGN_ERR_O next cycle; a simultaneous set wins.
- Cycles with PIX_VLD_I=0: no state change; gaps inside a group are allowed.
- C_PORT_NUM=1: every accepted pixel is emitted next cycle; flush and ALIGN_ERR_O are never asserted.
- Reset mid-group: buffered pixels are discarded, no output.

Decomposition:
- Shared package lvds_map_pkg:
  - Bit-position constants for HS/VS/DE and the R/G/B index lists.
  - LVDS_WORD_W=28, reserved bit index 3.
  - Reused by the receiver and this block so mappings cannot diverge.
- Sub-module lvds_lane_pack: purely combinational; 8/8/8 RGB plus HS/VS/DE -> 28-bit word. Instantiated C_PORT_NUM times on the group buffer.
- Top holds counter, group buffer, flush logic and output register.

Test Plan:
- C_PORT_NUM=4: DE=1, four pixels R=FF, G=B=0, HS=VS=0, back-to-back -> one strobe 1 cycle after the 4th; each lane = 0x9911114.
- Single pixel, G=FF, DE=0 (C_PORT_NUM=1) -> word 0x22AA201. Pixels with only HS -> 0x400; only VS -> 0x40; bit 3 always 0.
- C_PORT_NUM=4: 4 pixels with PIX_VLD_I toggling 1/0 -> exactly one strobe, 1 cycle after the 4th valid; lane order = arrival order, port 0 at LSB.
- Active line of 6 pixels (DE=1), then DE=0 pixel:
  - Strobe after pixel 4.
  - Flush strobe with lanes 0-1 = pixels 5-6, lanes 2-3 = 0x0 except copied HS/VS.
  - ALIGN_ERR_O=1 until ERR_CLR_I.
- Blanking of 3 pixels, then DE rises -> flush of 3-pixel group, ALIGN_ERR_O stays 0; new line's first pixel lands in lane 0.
- Assert RSTN_I low after 2 pixels of a group -> all outputs 0 immediately; after release, 4 new pixels produce one clean group with no stale data.
